// File: rtl/regfile_pkg.sv
// Shared register-file types and helpers for the LVT register file and rename/issue blocks.
// Latency: none (declarations only).
// Backpressure: not applicable.
package regfile_pkg;

  // Widest data path any register file instance may use; slices of ZERO_DATA give typed zeros.
  localparam int unsigned MAX_DATA_WIDTH = 1024;
  localparam logic [MAX_DATA_WIDTH-1:0] ZERO_DATA = '0;

  // Width of one live-value-table entry: enough bits to name a write port, never zero.
  function automatic int unsigned lvt_width(input int unsigned ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  // Low bit of port 'port' inside a flat bus of 'width'-bit lanes.
  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/simple_dual_port_ram.sv
// One write port, one registered read port block RAM; read-first on same-address access.
// Latency: read data is registered, valid one cycle after re_i.
// Backpressure: none; the read register holds while re_i is low. No reset on storage or output.
module simple_dual_port_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read samples the old contents when the same address is written in this cycle.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/register_file_multiport_lvt.sv
// W-write / R-read register file from replicated 1W1R RAMs, live-value table picks the newest bank.
// Latency: 1 cycle read (registered); optional write-first bypass via macro REGFILE_BYPASS_EN.
// Backpressure: none; every port accepts every cycle, clk_en low freezes all state.
module register_file_multiport_lvt
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int REG_COUNT   = 256,
  parameter int ADDR_WIDTH  = $clog2(REG_COUNT),
  parameter int WRITE_PORTS = 4,
  parameter int READ_PORTS  = 8
) (
  input  logic                             clk,
  input  logic                             async_rst,
  input  logic                             clk_en,
  input  logic [WRITE_PORTS-1:0]           wr_en,
  input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] wr_addr,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic [READ_PORTS-1:0]            rd_en,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [READ_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [READ_PORTS-1:0]            rd_valid,
  output logic                             wr_conflict
);

  localparam int LW = lvt_width(WRITE_PORTS);
  localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH+1)'(REG_COUNT);
  localparam logic [DATA_WIDTH-1:0] ZERO_D = ZERO_DATA[DATA_WIDTH-1:0];

  typedef logic [LW-1:0]         lvt_idx_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  // Unpacked per-port views of the flat buses
  addr_t wa [WRITE_PORTS];
  data_t wd [WRITE_PORTS];
  addr_t ra [READ_PORTS];
  logic [WRITE_PORTS-1:0] w_ok;
  logic [READ_PORTS-1:0]  r_ok;

  // Live-value table and valid bitmap
  lvt_idx_t         lvt_q [REG_COUNT];
  logic [REG_COUNT-1:0] valid_q;

  // Per-read-port output stage: either a RAM bank (chosen by sel_q) or the alt_q word
  logic [READ_PORTS-1:0] rd_valid_q;
  logic [READ_PORTS-1:0] use_ram_q, use_ram_d;
  lvt_idx_t              sel_q   [READ_PORTS];
  lvt_idx_t              sel_d   [READ_PORTS];
  data_t                 alt_q   [READ_PORTS];
  data_t                 alt_d   [READ_PORTS];
  logic                  conflict_q, conflict_d;

  data_t ram_rd [WRITE_PORTS][READ_PORTS];

  genvar gi, gj;

  for (gi = 0; gi < WRITE_PORTS; gi++) begin : g_wport
    assign wa[gi]   = wr_addr[port_lsb(gi, ADDR_WIDTH) +: ADDR_WIDTH];
    assign wd[gi]   = wr_data[port_lsb(gi, DATA_WIDTH) +: DATA_WIDTH];
    // Out-of-range writes are dropped before they touch RAM or the LVT
    assign w_ok[gi] = wr_en[gi] && ({1'b0, wa[gi]} < REG_LIMIT);
  end

  for (gj = 0; gj < READ_PORTS; gj++) begin : g_rport
    assign ra[gj]   = rd_addr[port_lsb(gj, ADDR_WIDTH) +: ADDR_WIDTH];
    assign r_ok[gj] = rd_en[gj] && ({1'b0, ra[gj]} < REG_LIMIT);
    assign rd_data[port_lsb(gj, DATA_WIDTH) +: DATA_WIDTH] =
      use_ram_q[gj] ? ram_rd[sel_q[gj]][gj] : alt_q[gj];
    assign rd_valid[gj] = rd_valid_q[gj];
  end

  // Bank [i][j]: written only by write port i, read only by read port j
  for (gi = 0; gi < WRITE_PORTS; gi++) begin : g_bank_w
    for (gj = 0; gj < READ_PORTS; gj++) begin : g_bank_r
      simple_dual_port_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (REG_COUNT),
        .ADDR_WIDTH (ADDR_WIDTH)
      ) u_ram (
        .clk     (clk),
        .we_i    (clk_en && w_ok[gi]),
        .waddr_i (wa[gi]),
        .wdata_i (wd[gi]),
        .re_i    (clk_en && r_ok[gj]),
        .raddr_i (ra[gj]),
        .rdata_o (ram_rd[gi][gj])
      );
    end
  end

  // Flag any pair of accepted writes that target the same register
  always_comb begin
    conflict_d = 1'b0;
    for (int i = 0; i < WRITE_PORTS; i++) begin
      for (int k = i + 1; k < WRITE_PORTS; k++) begin
        if (w_ok[i] && w_ok[k] && (wa[i] == wa[k])) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  // Choose the source each read port will present after the next edge
  always_comb begin
    for (int j = 0; j < READ_PORTS; j++) begin
      use_ram_d[j] = r_ok[j] && valid_q[ra[j]];
      sel_d[j]     = lvt_q[ra[j]];
      alt_d[j]     = ZERO_D;
`ifdef REGFILE_BYPASS_EN
      // Write-first: the highest-index matching write overrides the stored value
      for (int i = 0; i < WRITE_PORTS; i++) begin
        if (r_ok[j] && w_ok[i] && (wa[i] == ra[j])) begin
          use_ram_d[j] = 1'b0;
          alt_d[j]     = wd[i];
        end
      end
`endif
    end
  end

  // LVT/valid update; ascending loop lets the highest write port win a collision
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        lvt_q[r] <= '0;
      end
      valid_q <= '0;
    end else if (clk_en) begin
      for (int i = 0; i < WRITE_PORTS; i++) begin
        if (w_ok[i]) begin
          lvt_q[wa[i]]   <= lvt_idx_t'(i);
          valid_q[wa[i]] <= 1'b1;
        end
      end
    end
  end

  // Read output stage and conflict pulse; idle ports keep their last selection
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      rd_valid_q <= '0;
      use_ram_q  <= '0;
      conflict_q <= 1'b0;
      for (int j = 0; j < READ_PORTS; j++) begin
        sel_q[j] <= '0;
        alt_q[j] <= ZERO_D;
      end
    end else if (clk_en) begin
      rd_valid_q <= rd_en;
      conflict_q <= conflict_d;
      for (int j = 0; j < READ_PORTS; j++) begin
        if (rd_en[j]) begin
          use_ram_q[j] <= use_ram_d[j];
          sel_q[j]     <= sel_d[j];
          alt_q[j]     <= alt_d[j];
        end
      end
    end
  end

  assign wr_conflict = conflict_q;

endmodule
